nes_prefetch_fetch_unit: RTL and testbench

- Next-generation 6502 instruction fetch for the NES CPU. It replaces the single-instruction OPCODE/DATA/VALID fetch sequence with a parametrised byte prefetch queue.
- Keeps up to MAX_OUTSTANDING byte reads in flight to program memory.
- Decodes instruction length (1-3 bytes) from the opcode and presents whole instructions with their PC to decode via valid/ready.
- Supports a redirect (branch/jump/interrupt) that flushes the queue and discards in-flight reads.

---
 rtl/nes_cpu_pkg.sv | 51 +++++
 rtl/nes_prefetch_fetch_unit_if.sv | 34 +++
 rtl/nes_byte_fifo.sv | 48 ++++
 rtl/nes_prefetch_fetch_unit.sv | 112 +++++++++++
 tb/tb_nes_prefetch_fetch_unit.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/nes_cpu_pkg.sv
// Shared types and helpers for the NES CPU front end: queue-status debug state, decoded
// instruction bundle and 6502 instruction-length decode.
package nes_cpu_pkg;

  localparam int unsigned BUF_DEPTH_DEFAULT       = 8;
  localparam int unsigned MAX_OUTSTANDING_DEFAULT = 2;
  localparam int unsigned MAX_INSTR_SIZE          = 3;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_OPCODE,
    FETCH_DATA,
    FETCH_VALID
  } fetch_state_t;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [15:0] operand;
    logic [1:0]  len;
    logic [15:0] pc;
  } instr_t;

  // Illegal (cc=11) opcodes decode as single-byte NOPs.
  function automatic logic [1:0] instr_len(logic [7:0] op);
    logic [2:0] bbb;
    logic [1:0] len;
    bbb = op[4:2];
    len = 2'd1;
    case (op[1:0])
      2'b01: begin
        if (bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111) len = 2'd3;
        else len = 2'd2;
      end
      2'b10: begin
        if (bbb == 3'b011 || bbb == 3'b111) len = 2'd3;
        else if (bbb == 3'b000 || bbb == 3'b001 || bbb == 3'b101) len = 2'd2;
        else len = 2'd1;
      end
      2'b00: begin
        if (op == 8'h00 || op == 8'h40 || op == 8'h60) len = 2'd1;
        else if (op == 8'h20) len = 2'd3;
        else if (bbb == 3'b011 || bbb == 3'b111) len = 2'd3;
        else if (bbb == 3'b010 || bbb == 3'b110) len = 2'd1;
        else len = 2'd2;
      end
      default: len = 2'd1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/nes_prefetch_fetch_unit_if.sv
// Bundle of memory-read, redirect and instruction-delivery signals around the fetch unit.
interface nes_prefetch_fetch_unit_if #(
  parameter int unsigned MEM_ADDR_SIZE = 16
);
  import nes_cpu_pkg::*;

  logic                     mem_req_valid;
  logic                     mem_req_ready;
  logic [MEM_ADDR_SIZE-1:0] mem_req_addr;
  logic                     mem_rsp_valid;
  logic [7:0]               mem_rsp_data;
  logic                     redirect_valid;
  logic [MEM_ADDR_SIZE-1:0] redirect_pc;
  logic                     instr_valid;
  logic                     instr_ready;
  logic [7:0]               instr_opcode;
  logic [15:0]              instr_operand;
  logic [1:0]               instr_len;
  logic [MEM_ADDR_SIZE-1:0] instr_pc;
  fetch_state_t             fetch_state;

  modport master (
    output mem_req_valid, mem_req_addr, instr_valid, instr_opcode, instr_operand, instr_len,
           instr_pc, fetch_state,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, instr_valid, instr_opcode, instr_operand, instr_len,
           instr_pc, fetch_state,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, redirect_valid, redirect_pc, instr_ready
  );

endinterface

// File: rtl/nes_byte_fifo.sv
// Byte queue with single push, 0-3 byte pop and a three-byte peek window at the head.
module nes_byte_fifo #(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [7:0]       push_data,
  input  logic [1:0]       pop_len,
  output logic [CNT_W-1:0] count,
  output logic [7:0]       peek0,
  output logic [7:0]       peek1,
  output logic [7:0]       peek2
);

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      rd_ptr_q <= rd_ptr_q + PTR_W'(pop_len);
      count_q  <= count_q + CNT_W'(push) - CNT_W'(pop_len);
    end
  end

  // Storage needs no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) mem_q[wr_ptr_q] <= push_data;
  end

  always_comb begin
    count = count_q;
    peek0 = mem_q[rd_ptr_q];
    peek1 = mem_q[rd_ptr_q + PTR_W'(1)];
    peek2 = mem_q[rd_ptr_q + PTR_W'(2)];
  end

endmodule

// File: rtl/nes_prefetch_fetch_unit.sv
// 6502 prefetching fetch unit: streams bytes from program memory into a queue and hands
// whole decoded-length instructions with their PC to decode.
module nes_prefetch_fetch_unit
  import nes_cpu_pkg::*;
#(
  parameter int unsigned              MEM_ADDR_SIZE   = 16,
  parameter logic [MEM_ADDR_SIZE-1:0] BOOT_ADDR       = '0,
  parameter int unsigned              BUF_DEPTH       = BUF_DEPTH_DEFAULT,
  parameter int unsigned              MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT
) (
  input logic                       clk,
  input logic                       rst,
  nes_prefetch_fetch_unit_if.master bus
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef logic [MEM_ADDR_SIZE-1:0] addr_t;

  addr_t            fetch_pc_q, fetch_pc_d;
  addr_t            head_pc_q, head_pc_d;
  logic [OUT_W-1:0] outstanding_q, outstanding_d;
  logic [OUT_W-1:0] discard_q, discard_d;

  logic [CNT_W-1:0] count;
  logic [7:0]       peek0, peek1, peek2;
  logic             req_hs, fifo_push, has_instr, instr_fire;
  logic [1:0]       pop_len;
  instr_t           instr;

  nes_byte_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.redirect_valid),
    .push      (fifo_push),
    .push_data (bus.mem_rsp_data),
    .pop_len   (pop_len),
    .count     (count),
    .peek0     (peek0),
    .peek1     (peek1),
    .peek2     (peek2)
  );

  always_comb begin
    instr.opcode = peek0;
    instr.len    = instr_len(peek0);
    instr.pc     = 16'(head_pc_q);
    unique case (instr.len)
      2'd3:    instr.operand = {peek2, peek1};
      2'd2:    instr.operand = {8'h00, peek1};
      default: instr.operand = 16'h0000;
    endcase
    has_instr = (count != '0) && (count >= CNT_W'(instr.len));
  end

  // Bytes already queued plus bytes in flight reserve queue slots, so a push never overflows.
  always_comb begin
    bus.mem_req_valid = !rst && !bus.redirect_valid &&
                        ((32'(count) + 32'(outstanding_q)) < BUF_DEPTH) &&
                        (32'(outstanding_q) < MAX_OUTSTANDING);
    bus.mem_req_addr  = fetch_pc_q;
    req_hs            = bus.mem_req_valid && bus.mem_req_ready;

    bus.instr_valid   = !rst && has_instr && !bus.redirect_valid;
    instr_fire        = bus.instr_valid && bus.instr_ready;
    pop_len           = instr_fire ? instr.len : 2'd0;
    bus.instr_opcode  = bus.instr_valid ? instr.opcode : 8'h00;
    bus.instr_operand = bus.instr_valid ? instr.operand : 16'h0000;
    bus.instr_len     = bus.instr_valid ? instr.len : 2'd0;
    bus.instr_pc      = bus.instr_valid ? addr_t'(instr.pc) : addr_t'(0);

    fifo_push = bus.mem_rsp_valid && (discard_q == '0);

    if (has_instr)          bus.fetch_state = FETCH_VALID;
    else if (count != '0)   bus.fetch_state = FETCH_DATA;
    else if (outstanding_q != '0) bus.fetch_state = FETCH_OPCODE;
    else                    bus.fetch_state = FETCH_IDLE;
  end

  always_comb begin
    outstanding_d = outstanding_q + OUT_W'(req_hs) - OUT_W'(bus.mem_rsp_valid);
    discard_d     = discard_q;
    fetch_pc_d    = fetch_pc_q + addr_t'(req_hs);
    head_pc_d     = head_pc_q + addr_t'(pop_len);
    if (bus.redirect_valid) begin
      // Every read still in flight after this cycle belongs to the old stream.
      discard_d  = outstanding_d;
      fetch_pc_d = bus.redirect_pc;
      head_pc_d  = bus.redirect_pc;
    end else if (bus.mem_rsp_valid && (discard_q != '0)) begin
      discard_d  = discard_q - OUT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= BOOT_ADDR;
      head_pc_q     <= BOOT_ADDR;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      head_pc_q     <= head_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

endmodule

// File: tb/tb_nes_prefetch_fetch_unit.sv
// Directed bench for the prefetch fetch unit with an in-order, variable-latency memory model.
module tb_nes_prefetch_fetch_unit;
  import nes_cpu_pkg::*;

  localparam int unsigned MAXO = 4;
  localparam int NVEC = 19;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nes_prefetch_fetch_unit_if #(.MEM_ADDR_SIZE(16)) ifc ();

  nes_prefetch_fetch_unit #(
    .MEM_ADDR_SIZE   (16),
    .BOOT_ADDR       (16'h0000),
    .BUF_DEPTH       (8),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  typedef struct {logic [15:0] addr; int unsigned due;} pend_t;
  typedef struct {logic [7:0] op; logic [7:0] b1; logic [7:0] b2; logic [1:0] len;} vec_t;
  typedef struct {logic [15:0] pc; logic [7:0] op; logic [15:0] operand; logic [1:0] len;} ins_t;

  logic [7:0]  mem [65536];
  pend_t       pend[$];
  ins_t        got[$];
  logic [15:0] req_log[$];
  vec_t        tbl[NVEC];
  int unsigned cyc, n_out, max_out, n_acc, lat_min, lat_max;
  int          total, bad, first;
  logic        last_ivalid, last_reqv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive response for the coming edge, log handshakes, advance to the next negedge.
  task automatic cycle();
    ins_t ins;
    if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
      ifc.mem_rsp_valid = 1'b1;
      ifc.mem_rsp_data  = mem[pend[0].addr];
      void'(pend.pop_front());
      n_out--;
    end else begin
      ifc.mem_rsp_valid = 1'b0;
      ifc.mem_rsp_data  = 8'h00;
    end
    #1;
    last_ivalid = ifc.instr_valid;
    last_reqv   = ifc.mem_req_valid;
    if (ifc.mem_req_valid && ifc.mem_req_ready) begin
      pend.push_back('{addr: ifc.mem_req_addr,
                       due: cyc + 1 + $urandom_range(lat_max, lat_min)});
      req_log.push_back(ifc.mem_req_addr);
      n_out++;
      n_acc++;
      if (n_out > max_out) max_out = n_out;
    end
    if (ifc.instr_valid && ifc.instr_ready) begin
      ins.pc = ifc.instr_pc; ins.op = ifc.instr_opcode;
      ins.operand = ifc.instr_operand; ins.len = ifc.instr_len;
      got.push_back(ins);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc = 16'h0000;
    ifc.instr_ready = 1'b0;
    ifc.mem_req_ready = 1'b1;
    pend.delete();
    got.delete();
    req_log.delete();
    n_out = 0; n_acc = 0; max_out = 0;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic run_until(input int n, input int budget, input string name);
    for (int k = 0; k < budget && got.size() < n; k++) cycle();
    if (got.size() < n) chk({name, "_timeout"}, got.size(), n);
  endtask

  task automatic check_stream(input logic [15:0] base);
    logic [15:0] pc;
    logic [15:0] opnd;
    pc = base;
    for (int i = 0; i < NVEC; i++) begin
      if (i >= got.size()) begin
        chk("stream_short", got.size(), NVEC);
        break;
      end
      opnd = (tbl[i].len == 2'd3) ? {tbl[i].b2, tbl[i].b1} :
             (tbl[i].len == 2'd2) ? {8'h00, tbl[i].b1} : 16'h0000;
      chk($sformatf("vec%0d_pc", i), got[i].pc, pc);
      chk($sformatf("vec%0d_op", i), got[i].op, tbl[i].op);
      chk($sformatf("vec%0d_len", i), got[i].len, tbl[i].len);
      chk($sformatf("vec%0d_operand", i), got[i].operand, opnd);
      pc = pc + 16'(tbl[i].len);
    end
  endtask

  task automatic chk_ins(input string name, input int idx, input logic [15:0] pc,
                         input logic [7:0] op, input logic [1:0] len, input logic [15:0] opnd);
    if (idx >= got.size()) begin
      chk({name, "_missing"}, got.size(), idx + 1);
    end else begin
      chk({name, "_pc"}, got[idx].pc, pc);
      chk({name, "_op"}, got[idx].op, op);
      chk({name, "_len"}, got[idx].len, len);
      chk({name, "_operand"}, got[idx].operand, opnd);
    end
  endtask

  initial begin
    logic [15:0] a;
    total = 0; bad = 0; cyc = 0;
    lat_min = 1; lat_max = 1;
    ifc.mem_rsp_valid = 1'b0; ifc.mem_rsp_data = 8'h00;
    ifc.redirect_valid = 1'b0; ifc.redirect_pc = 16'h0000;
    ifc.instr_ready = 1'b0; ifc.mem_req_ready = 1'b1;

    tbl = '{'{8'hEA, 8'h00, 8'h00, 2'd1}, '{8'hA9, 8'h05, 8'h00, 2'd2},
            '{8'h8D, 8'h00, 8'h02, 2'd3}, '{8'h20, 8'h34, 8'h12, 2'd3},
            '{8'h60, 8'h00, 8'h00, 2'd1}, '{8'hA2, 8'h7F, 8'h00, 2'd2},
            '{8'hBD, 8'h10, 8'h20, 2'd3}, '{8'h0A, 8'h00, 8'h00, 2'd1},
            '{8'h6C, 8'hFE, 8'hFF, 2'd3}, '{8'hD0, 8'hF0, 8'h00, 2'd2},
            '{8'h96, 8'h11, 8'h00, 2'd2}, '{8'hBE, 8'h22, 8'h33, 2'd3},
            '{8'h00, 8'h00, 8'h00, 2'd1}, '{8'h40, 8'h00, 8'h00, 2'd1},
            '{8'h24, 8'h55, 8'h00, 2'd2}, '{8'h2C, 8'h66, 8'h77, 2'd3},
            '{8'hFF, 8'h00, 8'h00, 2'd1}, '{8'h18, 8'h00, 8'h00, 2'd1},
            '{8'h85, 8'h99, 8'h00, 2'd2}};

    for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
    a = 16'h0000;
    for (int i = 0; i < NVEC; i++) begin
      mem[a] = tbl[i].op;
      if (tbl[i].len >= 2'd2) mem[a + 16'd1] = tbl[i].b1;
      if (tbl[i].len == 2'd3) mem[a + 16'd2] = tbl[i].b2;
      a = a + 16'(tbl[i].len);
    end
    {mem[16'h8000], mem[16'h8001], mem[16'h8002]} = {8'h2C, 8'h34, 8'h12};
    {mem[16'h8003], mem[16'h8004], mem[16'h8005], mem[16'h8006]} = {8'h99, 8'h78, 8'h56, 8'hFF};
    {mem[16'h9000], mem[16'h9001], mem[16'h9002]} = {8'hA9, 8'h42, 8'hE8};
    {mem[16'h9003], mem[16'h9004], mem[16'h9005]} = {8'h4C, 8'h00, 8'h90};

    // Reset state, sampled while reset is still held.
    @(negedge clk);
    do_reset();
    rst = 1'b1;
    #1;
    chk("rst_req_valid", ifc.mem_req_valid, 0);
    chk("rst_req_addr", ifc.mem_req_addr, 16'h0000);
    chk("rst_instr_valid", ifc.instr_valid, 0);
    chk("rst_instr_len", ifc.instr_len, 0);
    chk("rst_instr_pc", ifc.instr_pc, 0);
    chk("rst_fetch_state", ifc.fetch_state, FETCH_IDLE);
    @(negedge clk);

    // Table-driven stream, 1-cycle latency, decode always ready.
    do_reset();
    ifc.instr_ready = 1'b1;
    first = -1;
    for (int k = 0; k < 400 && got.size() < NVEC; k++) begin
      if (first < 0 && ifc.instr_valid) first = k;
      cycle();
    end
    chk("first_valid_cycle", first, 2);
    check_stream(16'h0000);

    // Backpressure: queue fills to exactly BUF_DEPTH, then drains without loss.
    do_reset();
    repeat (30) cycle();
    chk("fill_accepted", n_acc, 8);
    chk("fill_req_valid", ifc.mem_req_valid, 0);
    chk("fill_inflight", n_out, 0);
    chk("fill_instr_valid", ifc.instr_valid, 1);
    chk("fill_fetch_state", ifc.fetch_state, FETCH_VALID);
    chk("fill_hold_op", ifc.instr_opcode, 8'hEA);
    ifc.instr_ready = 1'b1;
    run_until(NVEC, 400, "fill");
    check_stream(16'h0000);

    // Redirect with two long-latency reads in flight.
    do_reset();
    lat_min = 4; lat_max = 4;
    cycle();
    cycle();
    ifc.redirect_valid = 1'b1; ifc.redirect_pc = 16'h8000; ifc.instr_ready = 1'b1;
    cycle();
    chk("redir_req_masked", last_reqv, 0);
    chk("redir_ivalid_masked", last_ivalid, 0);
    ifc.redirect_valid = 1'b0;
    got.delete(); req_log.delete();
    cycle();
    chk("redir_first_req", (req_log.size() > 0) ? 32'(req_log[0]) : 32'hDEAD, 16'h8000);
    run_until(3, 200, "redir");
    chk_ins("redir0", 0, 16'h8000, 8'h2C, 2'd3, 16'h1234);
    chk_ins("redir1", 1, 16'h8003, 8'h99, 2'd3, 16'h5678);
    chk_ins("redir2", 2, 16'h8006, 8'hFF, 2'd1, 16'h0000);

    // Redirect coinciding with a response and a ready decode.
    do_reset();
    lat_min = 2; lat_max = 2;
    ifc.instr_ready = 1'b1;
    first = 0;
    for (int k = 0; k < 40; k++) begin
      if (k >= 6 && pend.size() > 0 && pend[0].due <= cyc + 1 && ifc.instr_valid) begin
        first = 1;
        break;
      end
      cycle();
    end
    if (first == 0) chk("same_cycle_setup", 0, 1);
    ifc.redirect_valid = 1'b1; ifc.redirect_pc = 16'h9000;
    cycle();
    chk("same_ivalid_masked", last_ivalid, 0);
    ifc.redirect_valid = 1'b0;
    got.delete();
    chk("same_queue_empty", ifc.instr_valid, 0);
    run_until(3, 200, "same");
    chk_ins("same0", 0, 16'h9000, 8'hA9, 2'd2, 16'h0042);
    chk_ins("same1", 1, 16'h9002, 8'hE8, 2'd1, 16'h0000);
    chk_ins("same2", 2, 16'h9003, 8'h4C, 2'd3, 16'h9000);

    // Instruction spanning FFFF -> 0000.
    mem[16'hFFFE] = 8'h4C; mem[16'hFFFF] = 8'h34; mem[16'h0000] = 8'h12;
    do_reset();
    lat_min = 1; lat_max = 1;
    ifc.instr_ready = 1'b1;
    ifc.redirect_valid = 1'b1; ifc.redirect_pc = 16'hFFFE;
    cycle();
    ifc.redirect_valid = 1'b0;
    got.delete(); req_log.delete();
    run_until(2, 100, "wrap");
    if (req_log.size() >= 4) begin
      chk("wrap_req0", req_log[0], 16'hFFFE);
      chk("wrap_req2", req_log[2], 16'h0000);
      chk("wrap_req3", req_log[3], 16'h0001);
    end else chk("wrap_req_count", req_log.size(), 4);
    chk_ins("wrap0", 0, 16'hFFFE, 8'h4C, 2'd3, 16'h1234);
    chk_ins("wrap1", 1, 16'h0001, 8'hA9, 2'd2, 16'h0005);
    mem[16'h0000] = 8'hEA;

    // Random latency and random backpressure on both sides.
    do_reset();
    lat_min = 1; lat_max = 5;
    for (int k = 0; k < 3000 && got.size() < NVEC; k++) begin
      ifc.instr_ready = 1'($urandom_range(0, 1));
      ifc.mem_req_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    if (got.size() < NVEC) chk("rand_timeout", got.size(), NVEC);
    check_stream(16'h0000);
    chk("rand_max_outstanding", max_out <= MAXO, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
